// File: rtl/manual_input.sv
// manual_input: synchronizes and debounces the CPU step button (one-cycle step_pulse per press)
// and the switch bank (port_out plus port_chg strobe). Define MANUAL_INPUT_AUTOREPEAT_EN for held-button auto-repeat.
module manual_input #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic [WIDTH-1:0] sw_raw,
    output logic             step_pulse,
    output logic             btn_level,
    output logic [WIDTH-1:0] port_out,
    output logic             port_chg
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } state_t;

    logic             r_btn_s1, r_btn_s2;
    logic [WIDTH-1:0] r_sw_s1, r_sw_s2;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_btn_cnt, w_btn_cnt_nxt;
    logic             w_accept;
    logic             w_rep_fire;
    logic             r_step_pulse, r_btn_level;

    logic [CW-1:0]    r_sw_cnt;
    logic [WIDTH-1:0] r_port;
    logic             r_port_chg;
    logic             w_sw_moving, w_sw_settled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_btn_cnt    <= '0;
            r_step_pulse <= 1'b0;
            r_btn_level  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_btn_cnt    <= w_btn_cnt_nxt;
            r_step_pulse <= w_accept | w_rep_fire;
            r_btn_level  <= (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_WAIT);
        end
    end

    // Bounces while pressing fall back to IDLE; bounces while releasing return to HELD silently.
    always_comb begin
        w_state_nxt   = r_state;
        w_btn_cnt_nxt = r_btn_cnt;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_s2) begin
                    w_state_nxt   = S_PRESS_WAIT;
                    w_btn_cnt_nxt = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (!r_btn_s2) begin
                    w_state_nxt   = S_IDLE;
                    w_btn_cnt_nxt = '0;
                end else if (r_btn_cnt == CNT_LAST) begin
                    w_state_nxt   = S_HELD;
                    w_btn_cnt_nxt = '0;
                    w_accept      = 1'b1;
                end else begin
                    w_btn_cnt_nxt = r_btn_cnt + CNT_ONE;
                end
            end
            S_HELD: begin
                if (!r_btn_s2) begin
                    w_state_nxt   = S_RELEASE_WAIT;
                    w_btn_cnt_nxt = CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (r_btn_s2) begin
                    w_state_nxt   = S_HELD;
                    w_btn_cnt_nxt = '0;
                end else if (r_btn_cnt == CNT_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_btn_cnt_nxt = '0;
                end else begin
                    w_btn_cnt_nxt = r_btn_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_btn_cnt_nxt = '0;
            end
        endcase
    end

`ifdef MANUAL_INPUT_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic             w_rep_hold;

    // Counts only while staying in HELD, so it freezes across a release bounce.
    assign w_rep_hold = (r_state == S_HELD) && r_btn_s2;
    assign w_rep_fire = w_rep_hold &&
                        (r_rep_armed ? (r_rep_cnt == REP_W'(REPEAT_PERIOD - 1))
                                     : (r_rep_cnt == REP_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if ((w_state_nxt == S_IDLE) || w_accept) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else if (w_rep_hold) begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // The counter restarts on the edge where sw_s takes a new value, so acceptance
    // lands DEBOUNCE_CYCLES edges after the last change.
    assign w_sw_moving  = (r_sw_s1 != r_sw_s2);
    assign w_sw_settled = (r_sw_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_cnt   <= '0;
            r_port     <= '0;
            r_port_chg <= 1'b0;
        end else begin
            if (w_sw_moving)
                r_sw_cnt <= '0;
            else if (!w_sw_settled)
                r_sw_cnt <= r_sw_cnt + CNT_ONE;
            r_port_chg <= 1'b0;
            if (w_sw_settled && (r_sw_s2 != r_port)) begin
                r_port     <= r_sw_s2;
                r_port_chg <= 1'b1;
            end
        end
    end

    assign step_pulse = r_step_pulse;
    assign btn_level  = r_btn_level;
    assign port_out   = r_port;
    assign port_chg   = r_port_chg;

endmodule

// File: tb/tb_manual_input.sv
// Bench for manual_input: hand table, directed multi-cycle corner cases, then random stimulus
// against a timing-rule reference model (D consecutive disagreeing samples flip the level).
module tb_manual_input;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef MANUAL_INPUT_AUTOREPEAT_EN
    localparam int EXP_HOLD_PULSES   = 5;
    localparam int EXP_BOUNCE_PULSES = 2;
`else
    localparam int EXP_HOLD_PULSES   = 1;
    localparam int EXP_BOUNCE_PULSES = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_raw = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic         step_pulse, btn_level, port_chg;
    logic [W-1:0] port_out;

    always #5 clk = ~clk;

    manual_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .step_pulse(step_pulse), .btn_level(btn_level), .port_out(port_out), .port_chg(port_chg)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: sampled values seen through a 2-deep delay, level flips after D
    // consecutive samples that disagree with it; switches accepted D edges after last change.
    logic         m_b1, m_b2, m_lvl, m_pulse, m_chg;
    logic [W-1:0] m_s1, m_s2, m_port;
    int           m_run, m_hold, m_edge, m_tchg;

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_lvl = 0; m_pulse = 0; m_chg = 0;
        m_s1 = '0; m_s2 = '0; m_port = '0;
        m_run = 0; m_hold = 0; m_edge = 0; m_tchg = 0;
    endtask

    task automatic model_edge(input logic b, input logic [W-1:0] s);
        m_pulse = 0;
        if (m_b2 != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_lvl = m_b2;
                m_run = 0;
                if (m_lvl) begin
                    m_pulse = 1;
                    m_hold  = 0;
                end
            end
        end else begin
`ifdef MANUAL_INPUT_AUTOREPEAT_EN
            if (m_lvl && m_run == 0) begin
                m_hold++;
                if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) m_pulse = 1;
            end
`endif
            m_run = 0;
        end
        m_edge++;
        m_chg = 0;
        if ((m_edge - m_tchg) >= D && m_s2 != m_port) begin
            m_port = m_s2;
            m_chg  = 1;
        end
        if (m_s1 != m_s2) m_tchg = m_edge;
        m_b2 = m_b1; m_b1 = b;
        m_s2 = m_s1; m_s1 = s;
    endtask

    task automatic step();
        logic         b;
        logic [W-1:0] s;
        b = btn_raw;
        s = sw_raw;
        @(posedge clk);
        #1;
        model_edge(b, s);
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
        chk("port_out", 32'(port_out), 32'(m_port));
        chk("port_chg", 32'(port_chg), 32'(m_chg));
    endtask

    int p_cnt, p_first, c_first;
    task automatic clr_obs();
        p_cnt = 0; p_first = -1; c_first = -1;
    endtask
    task automatic obs(input int i);
        if (step_pulse) begin
            p_cnt++;
            if (p_first < 0) p_first = i;
        end
        if (port_chg && c_first < 0) c_first = i;
    endtask

    typedef struct {
        logic         btn;
        logic [W-1:0] sw;
        logic         pulse;
        logic         lvl;
        logic [W-1:0] port;
        logic         chg;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int l_fall, l_min, blen;
        logic bv;
        logic [0:4] pat;

        // press accepted after edge 5, release seen at edge 8 -> level drops at edge 11;
        // A5 with a 25 glitch: last sw_s change at edge 6 -> port_out A5 at edge 10
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h25, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[11] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[12] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};

        model_reset();
        @(posedge clk);
        #1;
        chk("reset step_pulse", 32'(step_pulse), 32'd0);
        chk("reset btn_level", 32'(btn_level), 32'd0);
        chk("reset port_out", 32'(port_out), 32'd0);
        chk("reset port_chg", 32'(port_chg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            btn_raw = tbl[i].btn;
            sw_raw  = tbl[i].sw;
            @(posedge clk);
            #1;
            model_edge(tbl[i].btn, tbl[i].sw);
            chk($sformatf("tbl[%0d].step_pulse", i), 32'(step_pulse), 32'(tbl[i].pulse));
            chk($sformatf("tbl[%0d].btn_level", i), 32'(btn_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl[%0d].port_out", i), 32'(port_out), 32'(tbl[i].port));
            chk($sformatf("tbl[%0d].port_chg", i), 32'(port_chg), 32'(tbl[i].chg));
        end

        // clean press held 30 steps, then release
        clr_obs();
        l_fall = -1;
        for (int i = 1; i <= 30; i++) begin
            btn_raw = 1'b1;
            step();
            obs(i);
        end
        for (int i = 31; i <= 40; i++) begin
            btn_raw = 1'b0;
            step();
            obs(i);
            if (!btn_level && l_fall < 0) l_fall = i;
        end
        chk("clean press pulse step", 32'(p_first), 32'd6);
        chk("clean press pulse count", 32'(p_cnt), 32'(EXP_HOLD_PULSES));
        chk("clean release level fall step", 32'(l_fall), 32'd36);

        // bouncy press 1,0,1,1,0 then steady
        pat = 5'b10110;
        clr_obs();
        for (int i = 1; i <= 17; i++) begin
            btn_raw = (i <= 5) ? pat[i-1] : 1'b1;
            step();
            obs(i);
        end
        chk("bouncy press pulse step", 32'(p_first), 32'd11);
        chk("bouncy press pulse count", 32'(p_cnt), 32'd1);

        // two-cycle release bounce while held
        clr_obs();
        l_min = 1;
        for (int i = 1; i <= 12; i++) begin
            btn_raw = (i <= 2) ? 1'b0 : 1'b1;
            step();
            obs(i);
            if (!btn_level) l_min = 0;
        end
        chk("release bounce level held", 32'(l_min), 32'd1);
        chk("release bounce pulse count", 32'(p_cnt), 32'(EXP_BOUNCE_PULSES));
        for (int i = 0; i < 10; i++) begin
            btn_raw = 1'b0;
            step();
        end

        // reset during PRESS_WAIT with button and new switches held
        for (int i = 0; i < 4; i++) begin
            btn_raw = 1'b1;
            sw_raw  = 8'h3C;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset step_pulse", 32'(step_pulse), 32'd0);
        chk("async reset btn_level", 32'(btn_level), 32'd0);
        chk("async reset port_out", 32'(port_out), 32'd0);
        chk("async reset port_chg", 32'(port_chg), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clr_obs();
        for (int i = 1; i <= 10; i++) begin
            step();
            obs(i);
        end
        chk("post-reset pulse step", 32'(p_first), 32'(D + 2));
        chk("post-reset pulse count", 32'(p_cnt), 32'd1);
        chk("post-reset port_chg step", 32'(c_first), 32'(D + 2));
        chk("post-reset port_out", 32'(port_out), 32'h3C);

        // random runs of button levels and switch changes/glitches
        blen = 0;
        bv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (blen == 0) begin
                bv   = 1'($urandom_range(0, 1));
                blen = $urandom_range(1, 9);
            end
            blen--;
            btn_raw = bv;
            if ($urandom_range(0, 7) == 0) sw_raw = W'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
